brick_collision_detector: RTL and testbench
===========================================

// Module: brick_collision_detector
// PURPOSE
//  Consumer end of the bitmap drawing interface: watches the player's drawingRequest and a brick
//  bitmap's drawingRequest/HitEdgeCode, detects pixel overlap and accumulates which brick edges
//  were touched during a frame. At each frame boundary it publishes one collision report to the
//  game controller over a valid/ack handshake. It also gives an immediate first-hit pulse.
// PARAMETERS
//  MIN_OVERLAP_PIXELS  4   overlap pixels per frame needed before a report is published
//  COUNT_WIDTH         12  width of the saturating overlap-pixel counter
// PORTS
//  clk                   in   1   pixel clock
//  resetN                in   1   asynchronous, active-low reset
//  startOfFrame          in   1   one-cycle pulse at frame start, from the VGA controller
//  playerDrawingRequest  in   1   player bitmap pixel is opaque
//  brickDrawingRequest   in   1   brick bitmap pixel is opaque; aligned with brickHitEdgeCode
//  brickHitEdgeCode      in   4   {Left,Top,Right,Bottom} edge code of the current brick pixel
//  collisionAck          in   1   controller consumed the report
//  collisionValid        out  1   report pending; held until acked
//  collisionEdgeCode     out  4   OR of all overlap edge codes of the reported frame
//  collisionPixelCount   out  COUNT_WIDTH  overlap pixels in the reported frame (saturated)
//  collisionOverrun      out  1   a pending report was overwritten before ack
//  firstHitPulse         out  1   one-cycle pulse on the first overlap pixel of a frame
// BEHAVIOUR
//  - Reset: all outputs 0, accumulators 0, FSM = WAIT_SOF.
//  - overlap = playerDrawingRequest & brickDrawingRequest (same cycle; both sources are registered).
//  - FSM WAIT_SOF: ignore overlap; on startOfFrame -> COLLECT (clear accumulators, no publish).
//    COLLECT: on overlap, accEdge |= brickHitEdgeCode, accCount += 1 (saturate at 2^COUNT_WIDTH-1).
//    On startOfFrame in COLLECT: publish the previous frame, then clear accumulators; stay in COLLECT.
//  - Overlap in the same cycle as startOfFrame belongs to the new frame. It seeds the cleared
//    accumulators: accEdge = code, accCount = 1.
//  - Publish condition: accCount >= MIN_OVERLAP_PIXELS. If it is false, nothing changes.
//    If it is true, then on the next edge: collisionValid=1, collisionEdgeCode=accEdge,
//    collisionPixelCount=accCount.
//  - Handshake: collisionValid stays 1 until a cycle with collisionAck=1. collisionValid clears
//    on the following edge. Data stays stable while valid. An ack while valid=0 is ignored.
//  - Publish while valid=1 with no ack that cycle: overwrite the data with the newer frame and set
//    collisionOverrun=1. Overrun clears on the edge that consumes an ack.
//  - Publish and ack in the same cycle: the publish wins. valid stays 1 with the new data, and
//    overrun is not set.
//  - firstHitPulse: registered, asserted the cycle after the first overlap in COLLECT for the
//    current frame. At most one per frame. Never asserted in WAIT_SOF.
//  - Latency: overlap pixel -> firstHitPulse 1 clk. startOfFrame -> collisionValid 1 clk.
//  - brickHitEdgeCode is sampled only when overlap=1. X on it otherwise must not propagate.
//  - Reset asserted mid-frame: immediate return to reset values. The next frame is only
//    collected after a startOfFrame has been seen.
// STRUCTURE
//  - Package collision_pkg: typedef logic[3:0] edge_code_t; EDGE_LEFT=3, EDGE_TOP=2,
//    EDGE_RIGHT=1, EDGE_BOTTOM=0; typedef enum {WAIT_SOF, COLLECT} coll_state_t.
//  - Sub-module frame_overlap_accum: holds accEdge/accCount/firstSeen, with clear, seed and
//    saturation. The top module holds the FSM, the publish register and the handshake.
// TESTING
//  - Reset, then 10 overlap cycles before any SOF -> no firstHitPulse, and valid stays 0 after the
//    first SOF.
//  - SOF; 5 overlaps with codes 4'h8,4'h8,4'hC,4'h4,4'h4; SOF -> next clk valid=1, edge=4'hC,
//    count=5, and one firstHitPulse in that frame.
//  - SOF; 3 overlaps (below MIN=4); SOF -> valid stays 0, and the next frame starts from count 0.
//  - Two qualifying frames with no ack -> second data shown, overrun=1. Then ack -> valid=0 and
//    overrun=0 the next clk.
//  - Ack in the same cycle as a publishing SOF -> valid stays 1, new data, overrun=0.
//  - COUNT_WIDTH=3 with 12 overlaps -> count=7. Overlap on the SOF cycle -> new frame count starts
//    at 1. resetN pulse mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/brick_collision_detector_pkg.sv
// Shared types for the brick collision detector.
//   edge_code_t  : {Left,Top,Right,Bottom} edge code of one brick pixel
//   EDGE_*       : bit positions inside edge_code_t
//   coll_state_t : frame-tracking FSM state
package collision_pkg;

  typedef logic [3:0] edge_code_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    COLLECT  = 1'b1
  } coll_state_t;

endpackage

// File: rtl/brick_collision_detector_if.sv
// Collision report channel from the detector (master) to the game controller (slave).
// Handshake: collisionValid rises with a report and stays high, with
// collisionEdgeCode/collisionPixelCount/collisionOverrun stable, until a cycle in
// which collisionAck=1; it drops on the following edge. Ack with valid=0 is ignored.
//   collisionValid      report pending
//   collisionEdgeCode   OR of all overlap edge codes of the reported frame
//   collisionPixelCount overlap pixels of the reported frame (saturated)
//   collisionOverrun    a pending report was overwritten before it was acked
//   collisionAck        controller consumed the report
interface brick_collision_detector_if #(
  parameter int COUNT_WIDTH = 12
);
  import collision_pkg::*;

  logic                   collisionValid;
  edge_code_t             collisionEdgeCode;
  logic [COUNT_WIDTH-1:0] collisionPixelCount;
  logic                   collisionOverrun;
  logic                   collisionAck;

  modport master (
    output collisionValid,
    output collisionEdgeCode,
    output collisionPixelCount,
    output collisionOverrun,
    input  collisionAck
  );

  modport slave (
    input  collisionValid,
    input  collisionEdgeCode,
    input  collisionPixelCount,
    input  collisionOverrun,
    output collisionAck
  );

endinterface

// File: rtl/brick_collision_detector_frame_overlap_accum.sv
// Per-frame overlap accumulator.
//   clk, resetN   pixel clock, asynchronous active-low reset
//   clear_i       frame boundary: drop the old frame's totals
//   hit_i         counted overlap pixel this cycle (already qualified by the FSM)
//   code_i        brick edge code, only looked at when hit_i=1
//   acc_edge_o    OR of edge codes seen so far this frame
//   acc_count_o   overlap pixels this frame, saturating at all-ones
//   first_hit_o   one-cycle pulse the cycle after the frame's first overlap
module frame_overlap_accum
  import collision_pkg::*;
#(
  parameter int COUNT_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   clear_i,
  input  logic                   hit_i,
  input  edge_code_t             code_i,
  output edge_code_t             acc_edge_o,
  output logic [COUNT_WIDTH-1:0] acc_count_o,
  output logic                   first_hit_o
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  edge_code_t             edge_q, edge_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   seen_q, seen_d;
  logic                   first_q, first_d;

  always_comb begin
    edge_d  = edge_q;
    count_d = count_q;
    seen_d  = seen_q;
    first_d = 1'b0;
    if (clear_i) begin
      // An overlap on the boundary cycle already belongs to the new frame, so it
      // seeds the cleared totals. The mux keeps an undriven code out when hit_i=0.
      edge_d  = hit_i ? code_i : '0;
      count_d = hit_i ? COUNT_ONE : '0;
      seen_d  = hit_i;
      first_d = hit_i;
    end else if (hit_i) begin
      edge_d  = edge_q | code_i;
      count_d = (count_q == '1) ? count_q : count_q + COUNT_ONE;
      seen_d  = 1'b1;
      first_d = ~seen_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edge_q  <= '0;
      count_q <= '0;
      seen_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      count_q <= count_d;
      seen_q  <= seen_d;
      first_q <= first_d;
    end
  end

  assign acc_edge_o  = edge_q;
  assign acc_count_o = count_q;
  assign first_hit_o = first_q;

endmodule

// File: rtl/brick_collision_detector.sv
// Brick collision detector: watches the player and brick drawing requests, counts
// overlapping pixels and the brick edges they touched over a frame, and on each
// startOfFrame publishes the previous frame's report on the report channel if it
// had at least MIN_OVERLAP_PIXELS overlaps.
//   clk, resetN                pixel clock, asynchronous active-low reset
//   startOfFrame               one-cycle frame-start pulse
//   playerDrawingRequest       player pixel opaque
//   brickDrawingRequest        brick pixel opaque (aligned with brickHitEdgeCode)
//   brickHitEdgeCode           edge code of the current brick pixel
//   firstHitPulse              one-cycle pulse after the first overlap of a frame
//   dbgState                   current FSM state
//   report                     collision report channel (master side)
module brick_collision_detector
  import collision_pkg::*;
#(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int COUNT_WIDTH        = 12
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playerDrawingRequest,
  input  logic        brickDrawingRequest,
  input  edge_code_t  brickHitEdgeCode,
  output logic        firstHitPulse,
  output coll_state_t dbgState,
  brick_collision_detector_if.master report
);

  coll_state_t            state_q, state_d;
  logic                   valid_q, valid_d;
  edge_code_t             edge_q, edge_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overrun_q, overrun_d;

  logic                   overlap;
  logic                   hit;
  logic                   publish;
  logic                   consume;
  edge_code_t             acc_edge;
  logic [COUNT_WIDTH-1:0] acc_count;
  logic                   first_hit;

  assign overlap = playerDrawingRequest & brickDrawingRequest;
  // Overlaps count while collecting, and also on the startOfFrame cycle that opens
  // a frame (including the very first one after WAIT_SOF).
  assign hit     = overlap & ((state_q == COLLECT) | startOfFrame);
  assign publish = startOfFrame & (state_q == COLLECT) &
                   (int'(acc_count) >= MIN_OVERLAP_PIXELS);
  assign consume = report.collisionAck & valid_q;

  frame_overlap_accum #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_accum (
    .clk         (clk),
    .resetN      (resetN),
    .clear_i     (startOfFrame),
    .hit_i       (hit),
    .code_i      (brickHitEdgeCode),
    .acc_edge_o  (acc_edge),
    .acc_count_o (acc_count),
    .first_hit_o (first_hit)
  );

  always_comb begin
    state_d = state_q;
    if (startOfFrame) begin
      state_d = COLLECT;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    edge_d    = edge_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (publish) begin
      // A publish beats a same-cycle ack; overrun only when an unacked report is lost.
      valid_d   = 1'b1;
      edge_d    = acc_edge;
      count_d   = acc_count;
      overrun_d = valid_q & ~report.collisionAck;
    end else if (consume) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= WAIT_SOF;
      valid_q   <= 1'b0;
      edge_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      edge_q    <= edge_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign report.collisionValid      = valid_q;
  assign report.collisionEdgeCode   = edge_q;
  assign report.collisionPixelCount = count_q;
  assign report.collisionOverrun    = overrun_q;
  assign firstHitPulse              = first_hit;
  assign dbgState                   = state_q;

endmodule

// File: tb/tb_brick_collision_detector.sv
module tb_brick_collision_detector;
  import collision_pkg::*;

  localparam int MIN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic       sof = 1'b0;
  logic       pdr = 1'b0;
  logic       bdr = 1'b0;
  logic [3:0] code = 4'h0;

  logic        pulse, pulse_s;
  coll_state_t st, st_s;

  brick_collision_detector_if #(.COUNT_WIDTH(12)) rif ();
  brick_collision_detector_if #(.COUNT_WIDTH(3))  rif_s ();

  brick_collision_detector #(.MIN_OVERLAP_PIXELS(MIN), .COUNT_WIDTH(12)) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (sof),
    .playerDrawingRequest (pdr),
    .brickDrawingRequest  (bdr),
    .brickHitEdgeCode     (code),
    .firstHitPulse        (pulse),
    .dbgState             (st),
    .report               (rif)
  );

  brick_collision_detector #(.MIN_OVERLAP_PIXELS(MIN), .COUNT_WIDTH(3)) dut_s (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (sof),
    .playerDrawingRequest (pdr),
    .brickDrawingRequest  (bdr),
    .brickHitEdgeCode     (code),
    .firstHitPulse        (pulse_s),
    .dbgState             (st_s),
    .report               (rif_s)
  );

  // ---------------- scoreboard / counters ----------------
  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame contents are kept as a list of overlap codes plus an unsaturated hit
  // count; the report is derived from them at publish time.
  logic [3:0] exp_q[$];
  bit         m_collecting;
  int         m_hits;
  bit         m_seen;
  bit         m_pulse;
  bit         m_valid;
  bit         m_overrun;
  logic [3:0] m_edge;
  int         m_hits_pub;

  function automatic logic [3:0] or_codes();
    logic [3:0] r = 4'h0;
    foreach (exp_q[i]) r = r | exp_q[i];
    return r;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_collecting = 0; m_hits = 0; m_seen = 0; m_pulse = 0;
    m_valid = 0; m_overrun = 0; m_edge = 4'h0; m_hits_pub = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit b,
                            input logic [3:0] c, input bit ack);
    bit ov;
    bit was_valid;
    ov = p & b;
    was_valid = m_valid;
    if (s && m_collecting && m_hits >= MIN) begin
      m_overrun  = was_valid && !ack;
      m_valid    = 1;
      m_edge     = or_codes();
      m_hits_pub = m_hits;
    end else if (ack && was_valid) begin
      m_valid   = 0;
      m_overrun = 0;
    end
    if (s) begin
      m_collecting = 1;
      exp_q.delete();
      m_hits  = 0;
      m_pulse = ov;
      m_seen  = ov;
      if (ov) begin
        exp_q.push_back(c);
        m_hits = 1;
      end
    end else begin
      m_pulse = 0;
      if (m_collecting && ov) begin
        m_pulse = !m_seen;
        m_seen  = 1;
        exp_q.push_back(c);
        m_hits++;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      check("valid",     rif.collisionValid,      m_valid);
      check("edge",      rif.collisionEdgeCode,   m_edge);
      check("count",     rif.collisionPixelCount, sat(m_hits_pub, 12));
      check("overrun",   rif.collisionOverrun,    m_overrun);
      check("pulse",     pulse,                   m_pulse);
      check("state",     (st == COLLECT),         m_collecting);
      check("valid_s",   rif_s.collisionValid,    m_valid);
      check("count_s",   rif_s.collisionPixelCount, sat(m_hits_pub, 3));
      check("overrun_s", rif_s.collisionOverrun,  m_overrun);
      check("pulse_s",   pulse_s,                 m_pulse);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s, input bit p, input bit b,
                       input logic [3:0] c, input bit ack);
    @(negedge clk);
    sof = s; pdr = p; bdr = b; code = c;
    rif.collisionAck = ack; rif_s.collisionAck = ack;
    @(posedge clk);
    model_step(s, p, b, c, ack);
    #2;
    pulse_cnt += int'(pulse);
  endtask

  task automatic overlaps(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 1, c, 0);
      drive(0, 1, 0, 4'bxxxx, 0);
    end
  endtask

  task automatic idle_inputs();
    sof = 0; pdr = 0; bdr = 0; code = 4'h0;
    rif.collisionAck = 0; rif_s.collisionAck = 0;
  endtask

  task automatic do_reset();
    check_en = 0;
    idle_inputs();
    resetN = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1;
    check_en = 1;
  endtask

  task automatic pin_report(input string tag, input bit v, input logic [3:0] e,
                            input int cnt, input int cnt_s, input bit ov);
    check({tag, ".valid"},   rif.collisionValid,        v);
    check({tag, ".edge"},    rif.collisionEdgeCode,     e);
    check({tag, ".count"},   rif.collisionPixelCount,   cnt);
    check({tag, ".count_s"}, rif_s.collisionPixelCount, cnt_s);
    check({tag, ".overrun"}, rif.collisionOverrun,      ov);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] codes5 [5];
    codes5 = '{4'h8, 4'h8, 4'hC, 4'h4, 4'h4};
    idle_inputs();
    model_reset();
    #1;
    check("reset.valid", rif.collisionValid, 0);
    check("reset.pulse", pulse, 0);
    do_reset();

    // Overlaps before any SOF are ignored.
    pulse_cnt = 0;
    overlaps(10, 4'hF);
    check("presof.pulses", pulse_cnt, 0);
    drive(1, 0, 0, 4'h0, 0);
    check("presof.valid", rif.collisionValid, 0);

    // Basic qualifying frame.
    drive(1, 0, 0, 4'h0, 0);
    pulse_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, codes5[i], 0);
      drive(0, 1, 0, 4'bxxxx, 0);
    end
    drive(1, 0, 0, 4'h0, 0);
    pin_report("basic", 1, 4'hC, 5, 5, 0);
    check("basic.pulses", pulse_cnt, 1);
    drive(0, 0, 0, 4'h0, 1);
    check("basic.acked", rif.collisionValid, 0);

    // Below threshold, then the following frame starts from zero.
    overlaps(3, 4'h2);
    drive(1, 0, 0, 4'h0, 0);
    check("short.valid", rif.collisionValid, 0);
    overlaps(4, 4'h1);
    drive(1, 0, 0, 4'h0, 0);
    pin_report("after_short", 1, 4'h1, 4, 4, 0);
    drive(0, 0, 0, 4'h0, 1);

    // Two qualifying frames without ack -> overrun.
    overlaps(4, 4'h1);
    drive(1, 0, 0, 4'h0, 0);
    pin_report("ovr1", 1, 4'h1, 4, 4, 0);
    overlaps(6, 4'h2);
    drive(1, 0, 0, 4'h0, 0);
    pin_report("ovr2", 1, 4'h2, 6, 6, 1);
    drive(0, 0, 0, 4'h0, 1);
    check("ovr.ack_valid", rif.collisionValid, 0);
    check("ovr.ack_overrun", rif.collisionOverrun, 0);

    // Ack on a publishing SOF: publish wins, no overrun.
    overlaps(5, 4'h8);
    drive(1, 0, 0, 4'h0, 0);
    overlaps(4, 4'h4);
    drive(1, 0, 0, 4'h0, 1);
    pin_report("ackpub", 1, 4'h4, 4, 4, 0);
    drive(0, 0, 0, 4'h0, 1);

    // Saturation in the narrow instance, and overlap on the SOF cycle.
    overlaps(12, 4'h1);
    pulse_cnt = 0;
    drive(1, 1, 1, 4'h2, 0);
    pin_report("sat", 1, 4'h1, 12, 7, 0);
    check("sofhit.pulse", pulse, 1);
    overlaps(3, 4'h8);
    check("sofhit.pulses", pulse_cnt, 1);
    drive(1, 0, 0, 4'h0, 1);
    pin_report("sofseed", 1, 4'hA, 4, 4, 0);
    drive(0, 0, 0, 4'h0, 1);

    // Reset in the middle of a frame with a pending report and a live pulse.
    overlaps(5, 4'h1);
    drive(1, 0, 0, 4'h0, 0);
    drive(0, 1, 1, 4'h4, 0);
    check_en = 0;
    resetN = 0;
    #1;
    pin_report("midrst", 0, 4'h0, 0, 0, 0);
    check("midrst.pulse", pulse, 0);
    check("midrst.state", (st == COLLECT), 0);
    model_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    resetN = 1;
    check_en = 1;
    pulse_cnt = 0;
    overlaps(6, 4'h3);
    check("postrst.pulses", pulse_cnt, 0);
    drive(1, 0, 0, 4'h0, 0);
    check("postrst.valid", rif.collisionValid, 0);
    overlaps(4, 4'h2);
    drive(1, 0, 0, 4'h0, 0);
    pin_report("postrst", 1, 4'h2, 4, 4, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit s, p, b, a;
      logic [3:0] c;
      s = ($urandom_range(0, 29) == 0);
      p = ($urandom_range(0, 1) == 1);
      b = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 9) < 3);
      c = (p & b) ? 4'($urandom_range(0, 15)) : 4'bxxxx;
      drive(s, p, b, c, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
